// File: rtl/led_scan_decoder.sv
// rtl/led_scan_decoder.sv - receive-side decoder for a 4-digit multiplexed 7-segment display
//
// Watches the active-low anode strobes and segment lines of a scanned display,
// captures each digit once its strobe and segments have been stable for
// SETTLE_CYCLES synchronized samples, decodes the pattern back to a hex nibble
// and publishes complete 4-digit frames.
//
// Optional feature macro: LED_DECODER_CHANGE_ONLY_EN (report a frame only when
// it differs from the last reported one; the first frame after reset always reports).
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   an3..an0              anode strobes, active low (an3 = leftmost digit)
//   a..g, dp              segment lines and decimal point, active low
//   digit_value[15:0]     last frame, [15:12] = an3 digit ... [3:0] = an0 digit
//   dp_flags[3:0]         decimal point lit per digit, same ordering
//   blank_mask[3:0]       digit had all segments off, same ordering
//   frame_valid           one-cycle pulse with each output update
//   seg_error             one-cycle pulse on capture of an undecodable pattern
//   anode_error           high each cycle more than one anode is low
//   timeout               one-cycle pulse when a partial frame is discarded
module led_scan_decoder #(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        an3,
    input  logic        an2,
    input  logic        an1,
    input  logic        an0,
    input  logic        a,
    input  logic        b,
    input  logic        c,
    input  logic        d,
    input  logic        e,
    input  logic        f,
    input  logic        g,
    input  logic        dp,
    output logic [15:0] digit_value,
    output logic [3:0]  dp_flags,
    output logic [3:0]  blank_mask,
    output logic        frame_valid,
    output logic        seg_error,
    output logic        anode_error,
    output logic        timeout
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;

    localparam logic [7:0]  SETTLE_N = 8'(SETTLE_CYCLES);
    localparam logic [19:0] TMO_LAST = 20'(TIMEOUT_CYCLES - 1);

    // Segment pattern {a..g}, 1 = lit -> {valid, nibble}
    function automatic logic [4:0] seg_decode(input logic [6:0] s);
        case (s)
            7'h7E: return 5'h10;
            7'h30: return 5'h11;
            7'h6D: return 5'h12;
            7'h79: return 5'h13;
            7'h33: return 5'h14;
            7'h5B: return 5'h15;
            7'h5F: return 5'h16;
            7'h70: return 5'h17;
            7'h7F: return 5'h18;
            7'h7B: return 5'h19;
            7'h77: return 5'h1A;
            7'h1F: return 5'h1B;
            7'h4E: return 5'h1C;
            7'h3D: return 5'h1D;
            7'h4F: return 5'h1E;
            7'h47: return 5'h1F;
            default: return 5'h00;
        endcase
    endfunction

    logic [11:0] raw, sync1, sync2;
    logic [3:0]  an_low;
    logic [6:0]  seg_lit;
    logic        dp_lit;
    logic        one_hot, multi;
    logic [1:0]  idx;
    logic [9:0]  cur_pat, prev_pat;

    logic [1:0]  state, state_next;
    logic [7:0]  cnt, cnt_next;
    logic        capture;

    logic [4:0]  dec;
    logic        cap_blank, cap_err;
    logic [15:0] stage_nib, new_nib;
    logic [3:0]  stage_dp, new_dp, stage_blank, new_blank, mask;
    logic        frame_done, report, tmo_hit;
    logic [19:0] tcnt;

    assign raw = {an3, an2, an1, an0, a, b, c, d, e, f, g, dp};

    // Reset to 1 so a reset looks like "nothing strobed, all segments off"
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    assign an_low  = ~sync2[11:8];
    assign seg_lit = ~sync2[7:1];
    assign dp_lit  = ~sync2[0];

    always_comb begin
        one_hot = 1'b1;
        multi   = 1'b0;
        idx     = 2'd0;
        case (an_low)
            4'b0001: idx = 2'd0;
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            4'b0000: one_hot = 1'b0;
            default: begin
                one_hot = 1'b0;
                multi   = 1'b1;
            end
        endcase
    end

    assign cur_pat = {idx, seg_lit, dp_lit};

    // The count restarts at 1 on any change of digit or segments. In HOLD the
    // previous index is the held digit, so an index change is a new digit.
    always_comb begin
        if (state == ST_SETTLE && cur_pat == prev_pat)
            cnt_next = cnt + 8'd1;
        else
            cnt_next = 8'd1;
        capture = one_hot && cnt_next == SETTLE_N &&
                  !(state == ST_HOLD && idx == prev_pat[9:8]);
        if (!one_hot)
            state_next = ST_IDLE;
        else if (capture)
            state_next = ST_HOLD;
        else if (state == ST_HOLD && idx == prev_pat[9:8])
            state_next = ST_HOLD;
        else
            state_next = ST_SETTLE;
    end

    assign dec       = seg_decode(seg_lit);
    assign cap_blank = (seg_lit == 7'd0);
    assign cap_err   = !cap_blank && !dec[4];

    // Staging with the digit being captured this cycle merged in
    always_comb begin
        new_nib   = stage_nib;
        new_dp    = stage_dp;
        new_blank = stage_blank;
        for (int i = 0; i < 4; i++) begin
            if (an_low[i]) begin
                new_nib[i*4 +: 4] = dec[3:0];
                new_dp[i]         = dp_lit;
                new_blank[i]      = cap_blank;
            end
        end
    end

    assign frame_done = capture && ((mask | an_low) == 4'hF);
    assign tmo_hit    = !capture && tcnt == TMO_LAST;

`ifdef LED_DECODER_CHANGE_ONLY_EN
    logic [23:0] last_rep;
    logic        have_rep;

    assign report = frame_done &&
                    (!have_rep || {new_nib, new_dp, new_blank} != last_rep);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_rep <= '0;
            have_rep <= 1'b0;
        end else if (report) begin
            last_rep <= {new_nib, new_dp, new_blank};
            have_rep <= 1'b1;
        end
    end
`else
    assign report = frame_done;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            prev_pat    <= '0;
            stage_nib   <= '0;
            stage_dp    <= '0;
            stage_blank <= '0;
            mask        <= '0;
            tcnt        <= '0;
            digit_value <= '0;
            dp_flags    <= '0;
            blank_mask  <= '0;
            frame_valid <= 1'b0;
            seg_error   <= 1'b0;
            anode_error <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= one_hot ? cnt_next : 8'd0;
            prev_pat    <= cur_pat;
            frame_valid <= report;
            seg_error   <= capture && cap_err;
            anode_error <= multi;
            timeout     <= tmo_hit;

            if (capture) begin
                stage_nib   <= new_nib;
                stage_dp    <= new_dp;
                stage_blank <= new_blank;
                mask        <= frame_done ? 4'h0 : (mask | an_low);
                tcnt        <= '0;
            end else if (tmo_hit) begin
                mask <= 4'h0;
                tcnt <= '0;
            end else begin
                tcnt <= tcnt + 20'd1;
            end

            if (report) begin
                digit_value <= new_nib;
                dp_flags    <= new_dp;
                blank_mask  <= new_blank;
            end
        end
    end

endmodule

// File: tb/tb_led_scan_decoder.sv
// tb/tb_led_scan_decoder.sv - self-checking bench for led_scan_decoder
module tb_led_scan_decoder;

    localparam int SETTLE = 4;
    localparam int TMO    = 100;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  an_n;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [15:0] digit_value;
    logic [3:0]  dp_flags, blank_mask;
    logic        frame_valid, seg_error, anode_error, timeout;

    always #5 clk = ~clk;

    led_scan_decoder #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset),
        .an3(an_n[3]), .an2(an_n[2]), .an1(an_n[1]), .an0(an_n[0]),
        .a(seg_n[6]), .b(seg_n[5]), .c(seg_n[4]), .d(seg_n[3]),
        .e(seg_n[2]), .f(seg_n[1]), .g(seg_n[0]), .dp(dp_n),
        .digit_value(digit_value), .dp_flags(dp_flags), .blank_mask(blank_mask),
        .frame_valid(frame_valid), .seg_error(seg_error),
        .anode_error(anode_error), .timeout(timeout)
    );

    int total = 0;
    int passed = 0;
    int fv_cnt = 0, se_cnt = 0, ae_cnt = 0, to_cnt = 0;

    always @(negedge clk) begin
        if (frame_valid) fv_cnt++;
        if (seg_error)   se_cnt++;
        if (anode_error) ae_cnt++;
        if (timeout)     to_cnt++;
    end

    // Reference glyphs, written as the lit segment letters
    string seg_str[16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg",
                           "acdefg", "abc", "abcdefg", "abcdfg", "abcefg",
                           "cdefg", "adef", "bcdeg", "adefg", "aefg"};

    // Frame being displayed; index 3 = an3
    logic [3:0]  fnib[4];
    bit          fdp[4], fblank[4], fbad[4];
    logic [23:0] last_rep;
    bit          have_rep;

    function automatic logic [6:0] lit_of(string s);
        logic [6:0] m = '0;
        for (int i = 0; i < s.len(); i++) m[6 - (int'(s[i]) - 97)] = 1'b1;
        return m;
    endfunction

    function automatic logic [6:0] pattern(int i);
        if (fblank[i]) return 7'd0;
        if (fbad[i])   return 7'b1000001;
        return lit_of(seg_str[fnib[i]]);
    endfunction

    function automatic logic [23:0] model_frame();
        logic [15:0] v;
        logic [3:0]  p, bl;
        for (int i = 0; i < 4; i++) begin
            v[i*4 +: 4] = (fblank[i] || fbad[i]) ? 4'h0 : fnib[i];
            p[i]        = fdp[i];
            bl[i]       = fblank[i];
        end
        return {v, p, bl};
    endfunction

    function automatic bit model_report(logic [23:0] fr);
`ifdef LED_DECODER_CHANGE_ONLY_EN
        return !have_rep || fr != last_rep;
`else
        return 1'b1;
`endif
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic set_frame(logic [15:0] v, logic [3:0] p, logic [3:0] bl);
        for (int i = 0; i < 4; i++) begin
            fnib[i] = v[i*4 +: 4];
            fdp[i] = p[i];
            fblank[i] = bl[i];
            fbad[i] = 1'b0;
        end
    endtask

    // Called at a negedge; returns at a negedge
    task automatic show(int i, int len, bit glitch);
        an_n = ~(4'b0001 << i);
        if (glitch) begin
            seg_n = 7'($urandom);
            dp_n  = 1'($urandom);
            repeat (2) @(negedge clk);
        end
        seg_n = ~pattern(i);
        dp_n  = ~fdp[i];
        repeat (len) @(negedge clk);
    endtask

    task automatic blank_lines(int n);
        an_n = '1;
        seg_n = '1;
        dp_n = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic scan(int len, int gap, bit glitch);
        for (int i = 3; i >= 0; i--) begin
            show(i, len, glitch);
            if (gap > 0) blank_lines(gap);
        end
    endtask

    task automatic expect_frame(string tag, int fv0);
        logic [23:0] fr;
        bit rep;
        blank_lines(12);
        fr  = model_frame();
        rep = model_report(fr);
        if (rep) begin
            last_rep = fr;
            have_rep = 1'b1;
        end
        chk({tag, "_pulses"}, fv_cnt - fv0, rep ? 1 : 0);
        chk({tag, "_value"}, digit_value, last_rep[23:8]);
        chk({tag, "_dp"}, dp_flags, last_rep[7:4]);
        chk({tag, "_blank"}, blank_mask, last_rep[3:0]);
    endtask

    initial begin
        int fv0, se0, ae0, to0, k_to, nto;
        logic [15:0] dv_hold;

        reset = 1'b1;
        have_rep = 1'b0;
        last_rep = '0;
        an_n = '1;
        seg_n = '1;
        dp_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {digit_value, dp_flags, blank_mask}, 0);
        chk("reset_pulses", {frame_valid, seg_error, anode_error, timeout}, 0);
        reset = 1'b0;
        @(negedge clk);

        // Static 1234, scanned twice
        set_frame(16'h1234, 4'h0, 4'h0);
        fv0 = fv_cnt; scan(20, 0, 0); expect_frame("f1234_a", fv0);
        fv0 = fv_cnt; scan(20, 1, 0); expect_frame("f1234_b", fv0);

        // A b C d, dp on an1, glitches at every strobe edge
        se0 = se_cnt;
        set_frame(16'hABCD, 4'b0010, 4'h0);
        fv0 = fv_cnt; scan(16, 0, 1); expect_frame("abcd_glitch", fv0);
        chk("abcd_no_seg_error", se_cnt - se0, 0);

        // Blank an0 digit
        set_frame(16'h7890, 4'h0, 4'b0001);
        fv0 = fv_cnt; scan(14, 2, 0); expect_frame("blank_an0", fv0);

        // Undecodable a+g on an2, then two anodes low for 3 cycles
        se0 = se_cnt; ae0 = ae_cnt;
        set_frame(16'h503C, 4'b1000, 4'h0);
        fbad[2] = 1'b1;
        fv0 = fv_cnt;
        show(3, 14, 0);
        show(2, 14, 0);
        an_n = 4'b1100;
        repeat (3) @(negedge clk);
        show(1, 14, 0);
        show(0, 14, 0);
        expect_frame("bad_seg", fv0);
        chk("seg_error_once", se_cnt - se0, 1);
        chk("anode_error_3", ae_cnt - ae0, 3);

        // Randomized scans against the model
        se0 = se_cnt;
        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < 4; i++) begin
                fnib[i] = 4'($urandom);
                fdp[i] = 1'($urandom);
                fblank[i] = ($urandom_range(0, 7) == 0);
                fbad[i] = 1'b0;
            end
            fv0 = fv_cnt;
            scan($urandom_range(10, 30), $urandom_range(0, 2), 1'($urandom));
            expect_frame($sformatf("rand%0d", n), fv0);
        end
        chk("rand_no_seg_error", se_cnt - se0, 0);

        // Partial frame abandoned: only an3, an2 shown
        dv_hold = digit_value;
        fv0 = fv_cnt; to0 = to_cnt;
        set_frame(16'hE5F6, 4'h0, 4'h0);
        show(3, 20, 0);
        an_n = ~4'b0100;
        seg_n = ~pattern(2);
        dp_n = 1'b1;
        k_to = -1; nto = 0;
        for (int k = 1; k <= 150; k++) begin
            @(negedge clk);
            if (k == 20) begin
                an_n = '1;
                seg_n = '1;
            end
            if (timeout) begin
                nto++;
                if (k_to < 0) k_to = k;
            end
        end
        chk("timeout_count", nto, 1);
        chk("timeout_delay", k_to, 2 + SETTLE + TMO);
        chk("timeout_value_held", digit_value, dv_hold);
        chk("timeout_no_frame", fv_cnt - fv0, 0);
        set_frame(16'h2468, 4'b0101, 4'h0);
        fv0 = fv_cnt; scan(18, 0, 0); expect_frame("after_timeout", fv0);

        // Reset in the middle of a frame
        set_frame(16'h5678, 4'h0, 4'h0);
        show(3, 14, 0);
        show(2, 14, 0);
        an_n = ~4'b0010;
        seg_n = ~pattern(1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midreset_outputs", {digit_value, dp_flags, blank_mask}, 0);
        chk("midreset_pulses", {frame_valid, seg_error, anode_error, timeout}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        have_rep = 1'b0;
        last_rep = '0;
        fv0 = fv_cnt;
        repeat (15) @(negedge clk);
        show(0, 14, 0);
        blank_lines(12);
        chk("midreset_no_frame", fv_cnt - fv0, 0);
        fv0 = fv_cnt; scan(14, 0, 0); expect_frame("midreset_full", fv0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/led_scan_decoder.md
Name: led_scan_decoder

Overview:
Receive-side counterpart of the four-digit multiplexed 7-segment driver. Monitors the active-low anode strobes (an3..an0) and segment lines (a..g, dp), and samples each digit once its strobe has settled. Decodes each segment pattern back to a hex nibble and reassembles the full 4-digit frame. Used as a self-checking monitor in driver benches and as a loop-back checker on board.

Parameters:
SETTLE_CYCLES, 4, consecutive identical synchronized samples (same anode, same segments) required before a digit is captured; legal range 1..255
TIMEOUT_CYCLES, 65535, cycles without any capture before the partial frame is discarded; legal range 16..2^20-1

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
an3, an2, an1, an0  input  1 each  anode strobes, active low; an3 = leftmost digit
a, b, c, d, e, f, g  input  1 each  segment lines, active low
dp  input  1  decimal point, active low
digit_value  output  16  last complete frame; [15:12] = an3 digit ... [3:0] = an0 digit
dp_flags  output  4  dp lit per digit, same ordering
blank_mask  output  4  digit was blank (all segments off), same ordering
frame_valid  output  1  one-cycle pulse when digit_value, dp_flags and blank_mask update
seg_error  output  1  one-cycle pulse on capture of an undecodable pattern
anode_error  output  1  one-cycle pulse when more than one anode is low
timeout  output  1  one-cycle pulse when the partial frame is discarded

Behaviour:
- All 12 inputs pass through 2-flop synchronizers. Synchronizer reset value is 1 (inactive).
- Reset (async, any time, including mid-frame):
  - All outputs go to 0.
  - Capture mask, staging registers, settle counter and timeout counter go to 0.
  - FSM goes to IDLE.
- Anode decode, on synchronized values:
  - Exactly one anode low: that digit is the active index.
  - No anode low: blanking gap.
  - Two or more low: anode_error pulses every cycle the condition holds, and the FSM forces IDLE.
- FSM states:
  - IDLE to SETTLE: exactly one anode is low. Settle counter loads 1.
  - SETTLE: counter increments each cycle that the index and the 8-bit segment vector equal the previous cycle's values. Any change reloads the counter to 1.
  - SETTLE to HOLD: counter reaches SETTLE_CYCLES. The digit is captured that cycle.
  - HOLD: no further capture until the index changes or a blanking gap occurs. Index change goes to SETTLE; no anode goes to IDLE.
- Capture:
  - Decode {a..g} (1 = lit, after inversion): 0=abcdef, 1=bc, 2=abdeg, 3=abcdg, 4=bcfg, 5=acdfg, 6=acdefg, 7=abc, 8=abcdefg, 9=abcdfg, A=abcefg, b=cdefg, C=adef, d=bcdeg, E=adefg, F=aefg.
  - All segments off: nibble 0 and the staged blank bit is set.
  - Any other pattern: nibble 0 and seg_error pulses. The digit still counts as captured.
  - dp is staged separately.
  - The staging slot for the digit is overwritten if that digit is captured again before the frame completes.
  - The digit's bit is set in the 4-bit capture mask.
- Frame completion:
  - Triggered in the cycle the mask becomes 1111.
  - Staging is copied to digit_value, dp_flags and blank_mask.
  - frame_valid pulses on the next cycle, coincident with the updated outputs.
  - The mask clears in the same cycle; a capture that same cycle starts the new mask.
- Timeout:
  - The counter increments every cycle and clears on any capture.
  - At TIMEOUT_CYCLES: timeout pulses, the mask clears, the counter clears, and outputs hold their previous frame.
- Latency: 2 sync cycles + SETTLE_CYCLES to capture, + 1 cycle to frame_valid after the last digit.

Optional Feature:
LED_DECODER_CHANGE_ONLY_EN
- Defined: adds a 24-bit last-reported register. frame_valid pulses, and the outputs update, only when {digit_value, dp_flags, blank_mask} of the new frame differs from the last reported frame. The first frame after reset always reports.
- Undefined: every completed frame pulses frame_valid.

Test Plan:
- Drive 0x1234, no dp, digit strobe 1000 cycles, SETTLE_CYCLES=4 -> first frame_valid after all four digits are captured, with digit_value=16'h1234, dp_flags=0, blank_mask=0. Thereafter one pulse per scan.
- Display A, b, C, d with dp on digit an1, and 2-cycle glitch segments at each strobe edge -> digit_value=16'hABCD, dp_flags=4'b0010. No seg_error, because glitches never settle.
- an0 digit blank, others 7, 8, 9 -> digit_value=16'h7890, blank_mask=4'b0001.
- Force pattern a+g only on an2; then force an1 and an0 low together for 3 cycles -> seg_error single pulse. anode_error high for exactly 3 cycles after the sync delay. Frame still completes with nibble [11:8]=0.
- Stop the strobes after 2 digits, TIMEOUT_CYCLES=100 -> timeout pulse 100 cycles after the last capture. digit_value unchanged, and the next full scan reports correctly.
- Assert reset mid-frame, then deassert -> all outputs are 0 during reset. The first frame_valid occurs only after four fresh captures. With LED_DECODER_CHANGE_ONLY_EN, a static 0x1234 yields exactly one frame_valid.
